mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 data selector among four requesters.
- Each requester raises a request. The block grants exactly one requester at a time and drives the two-bit select into the selector datapath, forwarding the granted requester's data to a single output.
- It sits between the requester blocks and the shared output path.
- A hold limit prevents one requester from monopolising the selector while others wait.

Parameters:
- W, 8, width of each data input and of dout.
- MAX_HOLD, 4, maximum consecutive grant cycles before preemption when another request is pending (legal range 1..15).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = requester i.
- d0  input  W  requester 0 data.
- d1  input  W  requester 1 data.
- d2  input  W  requester 2 data.
- d3  input  W  requester 3 data.
- grant  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  registered select; sel = index of granted requester (bit0 = E0, bit1 = E1 of selector).
- busy  output  1  registered; 1 while any grant is active.
- dout  output  W  combinational selector output: d[sel] when busy, else 0.
- switch  output  1  one-cycle registered pulse on any cycle where grant changes to a different non-zero owner.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - grant=0, sel=0, busy=0, switch=0.
  - hold_cnt=0, state=IDLE.
  - last pointer=3, so requester 0 has first priority after reset.
- Round-robin search order from last pointer L: L+1, L+2, L+3, L (mod 4). The winner is the first set req bit in that order. last is updated to the winner on every new grant.
- IDLE:
  - req==0: stay IDLE.
  - Otherwise: next edge grant winner, sel=winner, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req rise to grant is 1 cycle.
- GRANT, owner o; evaluated each edge in this priority:
  1. req[o]==0 (release):
     - If other req bits are set, switch directly to the next winner with no idle bubble (switch=1, hold_cnt=0).
     - Otherwise go to IDLE with grant=0, busy=0, sel holding its last value.
  2. hold_cnt==MAX_HOLD-1 and some req[j]!=0 with j!=o (preempt): switch to the next winner (switch=1, hold_cnt=0). o keeps its request and is re-served in round-robin turn.
  3. Otherwise: keep grant; hold_cnt increments and saturates at MAX_HOLD-1.
- Grant from IDLE does not assert switch. switch is only for owner-to-owner changes.
- At most one grant bit is set at any time. grant, sel and busy change only on clock edges.
- Simultaneous release and timeout: release wins. Behaviour is identical anyway, since both pick the next winner.
- MAX_HOLD=1: an owner is preempted after each cycle whenever others wait. This gives strict per-cycle round robin.
- Requests dropping while not granted are simply not served; there is no request memory.
- Reset asserted mid-grant: outputs clear immediately (asynchronous). Arbitration restarts from requester 0.
- dout is combinational from the registered sel/busy and the data inputs; it adds no latency beyond sel.

Decomposition:
- Shared header of constants: state encodings (IDLE=1'b0, GRANT=1'b1), requester count 4, reset pointer value 3.
- One natural sub-module: mux4_sel, a parameterised W-bit 4-to-1 selector driven by sel[0]/sel[1] with an enable tied to busy.
- The arbiter FSM, pointer and hold counter live in the top level.

Test Plan:
- Reset then req=0001 held: cycle+1 grant=0001, sel=0, busy=1, dout=d0; req drops → next cycle grant=0000, busy=0, dout=0.
- req=1111 held continuously, MAX_HOLD=4:
  - Grant sequence is 0001 ×4 cycles, 0010 ×4, 0100 ×4, 1000 ×4, then repeat.
  - switch pulses at each change.
- Owner 1 granted, req=0110, req[1] drops: next cycle grant=0100 directly with no idle cycle; switch=1.
- Single requester req=0100 held for 20 cycles: grant stays 0100 throughout, no preemption, switch never asserted.
- Reset mid-grant (grant=1000, rst_n low for 3 ns between edges): grant=0, busy=0 immediately. After release with req=1001, first grant is 0001.
- Random req stimulus for 10k cycles:
  - grant is always one-hot or zero; sel matches the grant index; dout==d[sel] whenever busy.
  - No requester with req held waits more than 3×MAX_HOLD+3 cycles.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// rtl/mux4_rr_arbiter_pkg.sv - shared constants and helpers for the round-robin selector arbiter
package mux4_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int         NUM_REQ   = 4;
    localparam logic [1:0] RESET_PTR = 2'd3;

    // Search order is last+1, last+2, last+3, last; the nearest set bit wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last_v;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_v + k[1:0];
            if (req_v[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_sel.sv
// rtl/mux4_sel.sv - W-bit 4-to-1 data selector with enable, output forced to zero when disabled
module mux4_sel #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            case (sel)
                2'd0:    y = d0;
                2'd1:    y = d1;
                2'd2:    y = d2;
                default: y = d3;
            endcase
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter with hold limit sharing one 4-to-1 selector
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   grant,
    output logic [1:0]   sel,
    output logic         busy,
    output logic [W-1:0] dout,
    output logic         switch
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    arb_state_t state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       switch_q, switch_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] last_q, last_d;

    logic [3:0] others;
    logic [1:0] win_any;
    logic [1:0] win_others;

    assign others     = req & ~grant_q;
    assign win_any    = rr_pick(req, last_q);
    assign win_others = rr_pick(others, last_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        switch_d = 1'b0;
        hold_d   = hold_q;
        last_d   = last_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    grant_d = idx_to_onehot(win_any);
                    sel_d   = win_any;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    last_d  = win_any;
                end
            end
            default: begin
                // last_q equals the owner here, so the search naturally starts after it.
                if (!req[sel_q]) begin
                    if (|req) begin
                        grant_d  = idx_to_onehot(win_any);
                        sel_d    = win_any;
                        switch_d = 1'b1;
                        hold_d   = '0;
                        last_d   = win_any;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else if ((hold_q == HOLD_LAST) && (|others)) begin
                    grant_d  = idx_to_onehot(win_others);
                    sel_d    = win_others;
                    switch_d = 1'b1;
                    hold_d   = '0;
                    last_d   = win_others;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            switch_q <= 1'b0;
            hold_q   <= '0;
            last_q   <= RESET_PTR;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            switch_q <= switch_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign busy   = busy_q;
    assign switch = switch_q;

    mux4_sel #(.W(W)) u_sel (
        .en  (busy_q),
        .sel (sel_q),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .y   (dout)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed-vector bench for the round-robin selector arbiter
module tb_mux4_rr_arbiter;

    localparam int W        = 8;
    localparam int MAX_HOLD = 4;
    localparam int WAIT_MAX = 3 * MAX_HOLD + 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] d0 = 8'hA0;
    logic [W-1:0] d1 = 8'hB1;
    logic [W-1:0] d2 = 8'hC2;
    logic [W-1:0] d3 = 8'hD3;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         busy;
    logic [W-1:0] dout;
    logic         switch;

    int vectors = 0;
    int errors  = 0;

    mux4_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .d0     (d0),
        .d1     (d1),
        .d2     (d2),
        .d3     (d3),
        .grant  (grant),
        .sel    (sel),
        .busy   (busy),
        .dout   (dout),
        .switch (switch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic sw, input logic [W-1:0] dv);
        chk({tag, ".grant"},  32'(grant),  32'(g));
        chk({tag, ".sel"},    32'(sel),    32'(s));
        chk({tag, ".busy"},   32'(busy),   32'(b));
        chk({tag, ".switch"}, 32'(switch), 32'(sw));
        chk({tag, ".dout"},   32'(dout),   32'(dv));
    endtask

    initial begin
        logic [W-1:0] din [4];
        logic [3:0]   exp_g;
        logic [1:0]   gidx;
        logic         sel_ok;
        logic         wait_ok;
        int           wait_c [4];

        din[0] = 8'hA0; din[1] = 8'hB1; din[2] = 8'hC2; din[3] = 8'hD3;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;

        req = 4'b0001;
        tick();
        chk_all("single_grant", 4'b0001, 2'd0, 1'b1, 1'b0, 8'hA0);
        req = 4'b0000;
        tick();
        chk_all("single_release", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);

        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            tick();
            gidx  = 2'((k / 4) % 4);
            exp_g = 4'b0001 << gidx;
            chk_all("rr_all", exp_g, gidx, 1'b1, (k != 0) && (k % 4 == 0), din[gidx]);
        end

        req = 4'b0110;
        tick();
        chk_all("rel_to_1", 4'b0010, 2'd1, 1'b1, 1'b1, 8'hB1);
        req = 4'b0100;
        tick();
        chk_all("rel_no_bubble", 4'b0100, 2'd2, 1'b1, 1'b1, 8'hC2);

        for (int k = 0; k < 20; k++) begin
            tick();
            chk_all("solo_hold", 4'b0100, 2'd2, 1'b1, 1'b0, 8'hC2);
        end

        req = 4'b1000;
        tick();
        chk_all("to_owner3", 4'b1000, 2'd3, 1'b1, 1'b1, 8'hD3);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
        #2 rst_n = 1'b1;
        req = 4'b1001;
        tick();
        chk_all("post_reset", 4'b0001, 2'd0, 1'b1, 1'b0, 8'hA0);

        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
                din[i] = W'($urandom);
            end
            d0 = din[0]; d1 = din[1]; d2 = din[2]; d3 = din[3];
            tick();
            sel_ok = !busy || (grant == (4'b0001 << sel));
            chk("rand_onehot", 32'($onehot0(grant)), 32'd1);
            chk("rand_busy", 32'(busy), 32'(grant != 4'b0000));
            chk("rand_sel", 32'(sel_ok), 32'd1);
            chk("rand_dout", 32'(dout), busy ? 32'(din[sel]) : 32'd0);
            wait_ok = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !grant[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > WAIT_MAX) wait_ok = 1'b0;
            end
            chk("rand_wait", 32'(wait_ok), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
